// File: rtl/a429_rx_glitch_filter.sv
// ARINC429 receive line-leg glitch filter: a level change reaches dat_o only after LEN consecutive differing samples.
// Optional 2-flop input synchroniser enabled by defining A429_RX_FILTER_SYNC_EN.
module a429_rx_glitch_filter #(
  parameter int CLOCK_KHZ = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dat_i,
  input  logic spd_i,
  output logic dat_o
);

  localparam int BIT_CYCLES_100K = CLOCK_KHZ * 10 / 1000;
  localparam int FLT_HI          = (BIT_CYCLES_100K / 10 < 1) ? 1 : BIT_CYCLES_100K / 10;
  localparam int FLT_LO          = 8 * FLT_HI;
  localparam int CNT_W           = $clog2(FLT_LO) + 1;

  localparam logic [CNT_W-1:0] LIM_HI = CNT_W'(FLT_HI - 1);
  localparam logic [CNT_W-1:0] LIM_LO = CNT_W'(FLT_LO - 1);

  logic             w_smp;
  logic [CNT_W-1:0] w_lim;
  logic             r_dat;
  logic [CNT_W-1:0] r_cnt;

`ifdef A429_RX_FILTER_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;

  // input synchroniser stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= dat_i;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_smp = r_sync_p1;
`else
  assign w_smp = dat_i;
`endif

  // Window length follows spd_i every cycle, so a speed change acts on the running count.
  assign w_lim = spd_i ? LIM_HI : LIM_LO;

  // filter stage: any agreeing sample restarts qualification
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dat <= 1'b0;
      r_cnt <= '0;
    end else if (w_smp == r_dat) begin
      r_cnt <= '0;
    end else if (r_cnt >= w_lim) begin
      r_dat <= w_smp;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dat_o = r_dat;

endmodule

// File: tb/tb_a429_rx_glitch_filter.sv
// Directed bench for a429_rx_glitch_filter at CLOCK_KHZ=100000 (LEN 100 / 800), synchroniser disabled.
module tb_a429_rx_glitch_filter;

  logic clk_i = 1'b0;
  logic rst_i;
  logic dat_i;
  logic spd_i;
  logic dat_o;

  int n_chk  = 0;
  int n_pass = 0;
  logic r_seen;

  a429_rx_glitch_filter #(.CLOCK_KHZ(100000)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dat_i (dat_i),
    .spd_i (spd_i),
    .dat_o (dat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      r_seen = r_seen | dat_o;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst_i  = 1'b1;
    dat_i  = 1'b1;
    spd_i  = 1'b1;
    r_seen = 1'b0;

    // Reset held 3 clocks with the line high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_dat", 32'(dat_o), 0);
      chk("rst_cnt", 32'(dut.r_cnt), 0);
    end
    rst_i = 1'b0;
    dat_i = 1'b0;
    tick(2);

    // Rising then falling step at 100 kbps
    dat_i = 1'b1;
    tick(99);
    chk("rise_99", 32'(dat_o), 0);
    tick(1);
    chk("rise_100", 32'(dat_o), 1);
    dat_i = 1'b0;
    tick(99);
    chk("fall_99", 32'(dat_o), 1);
    tick(1);
    chk("fall_100", 32'(dat_o), 0);

    // 99-clock pulse rejected
    r_seen = 1'b0;
    dat_i  = 1'b1;
    tick(99);
    dat_i = 1'b0;
    tick(20);
    chk("rej_99_seen", 32'(r_seen), 0);
    chk("rej_99_cnt", 32'(dut.r_cnt), 0);

    // 100-clock pulse passes, delayed by 100
    dat_i = 1'b1;
    tick(99);
    chk("pul100_pre", 32'(dat_o), 0);
    tick(1);
    chk("pul100_on", 32'(dat_o), 1);
    dat_i = 1'b0;
    tick(99);
    chk("pul100_hold", 32'(dat_o), 1);
    tick(1);
    chk("pul100_off", 32'(dat_o), 0);

    // 12.5 kbps: 799 rejected, 800 accepted
    spd_i  = 1'b0;
    r_seen = 1'b0;
    dat_i  = 1'b1;
    tick(799);
    dat_i = 1'b0;
    tick(20);
    chk("rej_799_seen", 32'(r_seen), 0);
    dat_i = 1'b1;
    tick(799);
    chk("pul800_pre", 32'(dat_o), 0);
    tick(1);
    chk("pul800_on", 32'(dat_o), 1);
    dat_i = 1'b0;
    tick(799);
    chk("pul800_hold", 32'(dat_o), 1);
    tick(1);
    chk("pul800_off", 32'(dat_o), 0);

    // A single agreeing sample restarts the count
    spd_i = 1'b1;
    dat_i = 1'b1;
    tick(60);
    dat_i = 1'b0;
    tick(1);
    chk("restart_cnt", 32'(dut.r_cnt), 0);
    dat_i = 1'b1;
    tick(99);
    chk("restart_99", 32'(dat_o), 0);
    tick(1);
    chk("restart_100", 32'(dat_o), 1);
    dat_i = 1'b0;
    tick(100);
    chk("restart_back", 32'(dat_o), 0);

    // Speed switch mid-count takes effect on the next edge
    spd_i = 1'b0;
    dat_i = 1'b1;
    tick(500);
    chk("spd_cnt500", 32'(dut.r_cnt), 500);
    chk("spd_pre", 32'(dat_o), 0);
    spd_i = 1'b1;
    tick(1);
    chk("spd_switch", 32'(dat_o), 1);
    dat_i = 1'b0;
    tick(100);
    chk("spd_back", 32'(dat_o), 0);

    // Reset mid-count forces a full new window
    dat_i = 1'b1;
    tick(50);
    chk("mid_cnt50", 32'(dut.r_cnt), 50);
    rst_i = 1'b1;
    tick(1);
    chk("mid_rst_cnt", 32'(dut.r_cnt), 0);
    chk("mid_rst_dat", 32'(dat_o), 0);
    rst_i = 1'b0;
    tick(99);
    chk("mid_99", 32'(dat_o), 0);
    tick(1);
    chk("mid_100", 32'(dat_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
